// File: rtl/controlador_disco.sv
// DMA-style block mover between the disk model and main memory (start/busy/done handshake).
// Optional CONTROLADOR_DISCO_CHECKSUM_EN adds a wrapping 32-bit sum of every word written.
module controlador_disco #(
  parameter int unsigned DISK_SIZE = 100,
  parameter int unsigned MEM_SIZE  = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [31:0]      disk_base,
  input  logic [31:0]      mem_base,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_done,
  output logic [31:0]      disk_addr,
  output logic             disk_we,
  output logic [31:0]      disk_wdata,
  input  logic [31:0]      disk_rdata,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [31:0]      disk_base_q, disk_base_d;
  logic [31:0]      mem_base_q, mem_base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] words_done_q, words_done_d;
  logic             error_q, error_d;
  logic             hold_q, hold_d;
  logic [31:0]      disk_addr_q, disk_addr_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [32:0]      disk_end, mem_end;
  logic             range_bad;
  logic [CNT_W-1:0] idx_next;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
  logic [31:0]      checksum_q, checksum_d;
  logic [31:0]      src_rdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dir_q        <= 1'b0;
      disk_base_q  <= '0;
      mem_base_q   <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      words_done_q <= '0;
      error_q      <= 1'b0;
      hold_q       <= 1'b0;
      disk_addr_q  <= '0;
      mem_addr_q   <= '0;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      disk_base_q  <= disk_base_d;
      mem_base_q   <= mem_base_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      words_done_q <= words_done_d;
      error_q      <= error_d;
      hold_q       <= hold_d;
      disk_addr_q  <= disk_addr_d;
      mem_addr_q   <= mem_addr_d;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    disk_base_d  = disk_base_q;
    mem_base_d   = mem_base_q;
    count_d      = count_q;
    idx_d        = idx_q;
    words_done_d = words_done_q;
    error_d      = error_q;
    hold_d       = hold_q;
    disk_addr_d  = disk_addr_q;
    mem_addr_d   = mem_addr_q;
    disk_end     = {1'b0, disk_base_q} + 33'(count_q);
    mem_end      = {1'b0, mem_base_q} + 33'(count_q);
    range_bad    = (disk_end > 33'(DISK_SIZE)) || (mem_end > 33'(MEM_SIZE));
    idx_next     = idx_q + 1'b1;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
    checksum_d   = checksum_q;
    src_rdata    = dir_q ? mem_rdata : disk_rdata;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d        = dir;
          disk_base_d  = disk_base;
          mem_base_d   = mem_base;
          count_d      = count;
          words_done_d = '0;
          error_d      = 1'b0;
          hold_d       = 1'b0;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
          checksum_d   = '0;
`endif
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        // Empty or rejected commands spend a second CHECK cycle so done follows the second edge after start.
        if ((count_q == '0) || range_bad) begin
          error_d = (count_q != '0);
          if (hold_q) state_d = S_DONE;
          else        hold_d  = 1'b1;
        end else begin
          idx_d       = '0;
          disk_addr_d = disk_base_q;
          mem_addr_d  = mem_base_q;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        words_done_d = words_done_q + 1'b1;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
        checksum_d   = checksum_q + src_rdata;
`endif
        if (idx_q == count_q - 1'b1) begin
          state_d = S_DONE;
        end else begin
          idx_d       = idx_next;
          disk_addr_d = disk_base_q + 32'(idx_next);
          mem_addr_d  = mem_base_q + 32'(idx_next);
          state_d     = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy       = (state_q == S_CHECK) || (state_q == S_READ) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    disk_we    = (state_q == S_WRITE) && dir_q;
    mem_we     = (state_q == S_WRITE) && !dir_q;
    disk_wdata = disk_we ? mem_rdata : '0;
    mem_wdata  = mem_we ? disk_rdata : '0;
  end

  assign error      = error_q;
  assign words_done = words_done_q;
  assign disk_addr  = disk_addr_q;
  assign mem_addr   = mem_addr_q;
`ifdef CONTROLADOR_DISCO_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule
